// File: rtl/xor_parity_sched_pkg.sv
// Shared constants and state encoding for the bit-serial parity scheduler.
// Unused encoding 2'd3 is treated as IDLE by the FSM.
package xor_parity_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

endpackage

// File: rtl/xor_parity_sched_if.sv
// Request/result bundle between parity producers/consumer (master) and the scheduler (slave).
interface xor_parity_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_parity;
    logic [IDW-1:0]    res_id;
    logic              res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_parity, res_id
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_parity, res_id
    );
endinterface

// File: rtl/xor_parity_sched_cell.sv
// The single shared XOR resource; every parity bit of every requester goes through it.
module xor_bit_cell (
    input  logic a,
    input  logic b,
    output logic x
);
    assign x = a ^ b;
endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin arbiter feeding a bit-serial parity FSM around one shared XOR cell.
// Optional XOR_PARITY_SCHED_STATS_EN adds a 16-bit wrapping done_cnt output.
module xor_parity_sched
    import xor_parity_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    xor_parity_sched_if.slave bus
`ifdef XOR_PARITY_SCHED_STATS_EN
    ,
    output logic [15:0]       done_cnt
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(W + 1);

    state_t           state_r;
    state_t           state_nx;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   id_r;
    logic [W-1:0]     shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             acc_r;
    logic             res_valid_r;
    logic             xor_s;
    logic             grant_vld_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [NREQ-1:0]  grant_oh_s;
    int unsigned      scan_idx_s;

    xor_bit_cell u_xor (
        .a (acc_r),
        .b (shreg_r[0]),
        .x (xor_s)
    );

    // Round-robin scan: first pending requester at or above ptr_r, wrapping.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        scan_idx_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = (int'(ptr_r) + k) % NREQ;
            if (!grant_vld_s && bus.req_valid[scan_idx_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = IDW'(scan_idx_s);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        grant_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end

    // Grant is offered only while idle and out of reset.
    assign bus.req_ready  = (rst_n && state_r == S_IDLE && grant_vld_s) ? grant_oh_s : '0;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_parity = acc_r;
    assign bus.res_id     = id_r;

    // Next-state logic; the spare encoding falls back to IDLE.
    always_comb begin
        state_nx = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (grant_vld_s) state_nx = S_SHIFT;
                else             state_nx = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_r == CW'(1)) state_nx = S_DONE;
                else                 state_nx = S_SHIFT;
            end
            S_DONE: begin
                if (bus.res_ready) state_nx = S_IDLE;
                else               state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    // Datapath: capture on grant, shift one bit per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            id_r        <= '0;
            shreg_r     <= '0;
            cnt_r       <= '0;
            acc_r       <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_vld_s) begin
                        shreg_r <= bus.req_data[grant_idx_s*W +: W];
                        id_r    <= grant_idx_s;
                        acc_r   <= 1'b0;
                        cnt_r   <= CW'(W);
                    end
                end
                S_SHIFT: begin
                    acc_r   <= xor_s;
                    shreg_r <= shreg_r >> 1;
                    cnt_r   <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) res_valid_r <= 1'b1;
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        ptr_r       <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
                    end
                end
                default: res_valid_r <= 1'b0;
            endcase
        end
    end

`ifdef XOR_PARITY_SCHED_STATS_EN
    logic [15:0] done_cnt_r;

    // Completed-result counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 done_cnt_r <= 16'd0;
        else if (state_r == S_DONE && bus.res_ready) done_cnt_r <= done_cnt_r + 16'd1;
        else                                        done_cnt_r <= done_cnt_r;
    end

    assign done_cnt = done_cnt_r;
`endif

endmodule
